// File: rtl/bus_memory_if.sv
// CPU-side bus of the 6502 memory slave: PHI2 phase, address, direction and ready.
interface bus_memory_if;
    logic        PHI2;
    logic [15:0] ADDR;
    logic        RnW;
    logic        RDY;

    modport master (output PHI2, output ADDR, output RnW, input RDY);
    modport slave  (input PHI2, input ADDR, input RnW, output RDY);
endinterface

// File: rtl/bus_memory.sv
// 6502 external-bus memory slave: PHI2-framed reads/writes, programmable RDY wait
// states, backdoor loader with priority over CPU writes, and an access counter.
module bus_memory #(
    parameter int unsigned AW          = 12,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic          CLK,
    input  logic          n_RES,
    bus_memory_if.slave   bus,
    inout  wire  [7:0]    DataBus,
    input  logic          LOAD_WE,
    input  logic [AW-1:0] LOAD_ADDR,
    input  logic [7:0]    LOAD_DATA,
    output logic [15:0]   ACC_CNT,
    output logic          COLLIDE
);
    localparam logic [3:0] WS_C      = 4'(WAIT_STATES);
    localparam bit         NO_WAIT_C = (WAIT_STATES == 32'd0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t        state_r;
    logic          phi2_r;
    logic          rnw_r;
    logic          rdy_r;
    logic          collide_r;
    logic [AW-1:0] addr_r;
    logic [3:0]    wcnt_r;
    logic [15:0]   acc_cnt_r;
    logic [7:0]    rd_r;
    logic [7:0]    mem_r [0:(32'd1 << AW) - 32'd1];

    logic rise_s;
    logic fall_s;
    logic cap_s;
    logic cpu_wr_s;
    logic drive_s;
    logic addr_unused_s;

    // Upper address bits only mirror the array.
    assign addr_unused_s = ^bus.ADDR;

    // PHI2 edge detection, read-capture and bus-drive qualifiers.
    always_comb begin
        rise_s   = bus.PHI2 & ~phi2_r;
        fall_s   = ~bus.PHI2 & phi2_r;
        cpu_wr_s = n_RES & fall_s & (state_r == ST_DATA) & ~rnw_r;
        drive_s  = bus.PHI2 & (state_r == ST_DATA) & rnw_r;
        if (rise_s && (state_r != ST_WAIT)) begin
            cap_s = NO_WAIT_C;
        end else if (rise_s && (wcnt_r <= 4'd1)) begin
            cap_s = 1'b1;
        end else begin
            cap_s = 1'b0;
        end
    end

    assign DataBus = drive_s ? rd_r : 8'bzzzz_zzzz;
    assign bus.RDY = rdy_r;
    assign ACC_CNT = acc_cnt_r;
    assign COLLIDE = collide_r;

    // Previous PHI2 sample for edge detection.
    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            phi2_r <= 1'b0;
        end else begin
            phi2_r <= bus.PHI2;
        end
    end

    // Memory array and read capture; the loader wins over a CPU write and is not
    // gated by reset. A same-edge loader write leaves the captured read at the old byte.
    always_ff @(posedge CLK) begin
        if (LOAD_WE) begin
            mem_r[LOAD_ADDR] <= LOAD_DATA;
        end else if (cpu_wr_s) begin
            mem_r[addr_r] <= DataBus;
        end
        if (cap_s) begin
            rd_r <= mem_r[bus.ADDR[AW-1:0]];
        end
    end

    // Bus-cycle FSM with registered RDY, access counter and sticky collision flag.
    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            state_r   <= ST_IDLE;
            rdy_r     <= 1'b1;
            addr_r    <= '0;
            rnw_r     <= 1'b1;
            wcnt_r    <= 4'd0;
            acc_cnt_r <= 16'd0;
            collide_r <= 1'b0;
        end else begin
            if (cpu_wr_s && LOAD_WE) begin
                collide_r <= 1'b1;
            end
            case (state_r)
                // A rise while still in DATA restarts the access without counting it.
                ST_IDLE, ST_DATA: begin
                    if (rise_s) begin
                        addr_r <= bus.ADDR[AW-1:0];
                        rnw_r  <= bus.RnW;
                        if (NO_WAIT_C) begin
                            state_r <= ST_DATA;
                            rdy_r   <= 1'b1;
                        end else begin
                            state_r <= ST_WAIT;
                            wcnt_r  <= WS_C;
                            rdy_r   <= 1'b0;
                        end
                    end else if (fall_s && (state_r == ST_DATA)) begin
                        state_r   <= ST_IDLE;
                        acc_cnt_r <= acc_cnt_r + 16'd1;
                    end
                end
                ST_WAIT: begin
                    if (rise_s) begin
                        addr_r <= bus.ADDR[AW-1:0];
                        rnw_r  <= bus.RnW;
                        if (wcnt_r <= 4'd1) begin
                            state_r <= ST_DATA;
                            wcnt_r  <= 4'd0;
                            rdy_r   <= 1'b1;
                        end else begin
                            wcnt_r <= wcnt_r - 4'd1;
                            rdy_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    rdy_r   <= 1'b1;
                end
            endcase
        end
    end
endmodule
